// File: rtl/lcd_text_writer.sv
// ---------------------------------------------------------------------------
// lcd_text_writer
//
// Accepts a stream of character codes through a valid/ready port. The codes
// are buffered in a small FIFO and turned into HD44780-style commands for a
// downstream LCD controller, which is driven through a request/busy
// handshake. The block keeps a text cursor (column and line) and interprets
// two control codes:
//   0x0A newline   : set the DDRAM address to the start of the other line
//   0x0C form feed : clear the display and home the cursor
// Every other code is written as a data byte at the cursor.
//
// Optional feature macro: LCD_WRITER_AUTOWRAP_EN
//   defined   : a printable code arriving at column COLS first triggers an
//               internal set-address command for the other line, and is then
//               written at column 0 of that line.
//   undefined : a printable code arriving at column COLS is discarded.
//
// Parameters
//   DEPTH  FIFO depth in entries, power of two, 2..64
//   COLS   visible columns per line, 1..31
//
// Ports
//   clk          single clock, all logic on its rising edge
//   rst_n        synchronous active-low reset
//   wr_valid     producer offers wr_char
//   wr_char      character code
//   wr_ready     FIFO can accept (transfer on wr_valid && wr_ready)
//   lcd_busy     busy flag from the LCD controller
//   lcd_enable   command request to the LCD controller
//   lcd_bus      {rs, rw, data[7:0]} for the current command
//   cursor_col   current column, 0..COLS
//   cursor_line  current line, 0 or 1
//   idle         FIFO empty, FSM idle and no wrap pending
// ---------------------------------------------------------------------------
module lcd_text_writer #(
   parameter int DEPTH = 8,
   parameter int COLS  = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   input  logic [7:0] wr_char,
   output logic       wr_ready,
   input  logic       lcd_busy,
   output logic       lcd_enable,
   output logic [9:0] lcd_bus,
   output logic [4:0] cursor_col,
   output logic       cursor_line,
   output logic       idle
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [4:0]  COL_MAX  = 5'(COLS);
   localparam logic [7:0]  CH_NL    = 8'h0A;
   localparam logic [7:0]  CH_FF    = 8'h0C;
   localparam logic [9:0]  CMD_CLR  = 10'h001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      DONE = 2'd3
   } state_t;

   // What the DONE state must do to the cursor and FIFO for the command
   // currently in flight.
   typedef enum logic [1:0] {
      ACT_CHAR = 2'd0,
      ACT_NL   = 2'd1,
      ACT_FF   = 2'd2,
      ACT_WRAP = 2'd3
   } act_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // Control
   state_t        state;
   act_t          act;
   logic          wrap_pend;
   logic          alive;      // low for the cycles a reset is being applied

   // Decode of the FIFO head
   logic [7:0]    head;
   logic [9:0]    nl_bus;
   logic [9:0]    dec_bus;
   act_t          dec_act;
   logic          dec_drop;
   logic          start;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign wr_ready = alive && !full;
   assign push     = wr_valid && wr_ready;
   assign idle     = alive && empty && (state == IDLE) && !wrap_pend;

   // A new round may begin only when the controller reports not busy; this
   // also keeps the block quiet after a reset taken mid-transaction until the
   // controller has finished whatever it was doing.
   assign start = (state == IDLE) && !empty && !lcd_busy;

   // Entries leave the FIFO either when their command completes, or straight
   // from IDLE when an overflowing character is discarded. The wrap command
   // leaves its character in place so it is written on the next round.
   assign pop = (start && dec_drop) || ((state == DONE) && (act != ACT_WRAP));

   always_comb begin
      head     = mem[rptr];
      nl_bus   = {3'b001, (cursor_line ? 7'h00 : 7'h40)};
      dec_act  = ACT_CHAR;
      dec_bus  = {2'b10, head};
      dec_drop = 1'b0;
      if (head == CH_NL) begin
         dec_act = ACT_NL;
         dec_bus = nl_bus;
      end else if (head == CH_FF) begin
         dec_act = ACT_FF;
         dec_bus = CMD_CLR;
      end else if (cursor_col >= COL_MAX) begin
`ifdef LCD_WRITER_AUTOWRAP_EN
         dec_act = ACT_WRAP;
         dec_bus = nl_bus;
`else
         dec_drop = 1'b1;
`endif
      end
   end

   // FIFO data array carries no reset; its contents are only meaningful
   // between the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= wr_char;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         act         <= ACT_CHAR;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         lcd_enable  <= 1'b0;
         lcd_bus     <= '0;
         cursor_col  <= '0;
         cursor_line <= 1'b0;
         wrap_pend   <= 1'b0;
         alive       <= 1'b0;
      end else begin
         alive <= 1'b1;

         // Pointers wrap naturally because DEPTH is a power of two.
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end

         case (state)
            IDLE: begin
               if (start && !dec_drop) begin
                  lcd_bus    <= dec_bus;
                  act        <= dec_act;
                  wrap_pend  <= (dec_act == ACT_WRAP);
                  lcd_enable <= 1'b1;
                  state      <= REQ;
               end
            end

            // Request held with a stable bus until the controller takes it.
            REQ: begin
               if (lcd_busy) begin
                  lcd_enable <= 1'b0;
                  state      <= ACK;
               end
            end

            ACK: begin
               if (!lcd_busy) begin
                  state <= DONE;
               end
            end

            DONE: begin
               case (act)
                  ACT_CHAR: begin
                     if (cursor_col < COL_MAX) begin
                        cursor_col <= cursor_col + 5'd1;
                     end
                  end
                  ACT_NL: begin
                     cursor_line <= ~cursor_line;
                     cursor_col  <= '0;
                  end
                  ACT_FF: begin
                     cursor_line <= 1'b0;
                     cursor_col  <= '0;
                  end
                  ACT_WRAP: begin
                     cursor_line <= ~cursor_line;
                     cursor_col  <= '0;
                     wrap_pend   <= 1'b0;
                  end
                  default: ;
               endcase
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_writer.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_writer
//
// Bench for lcd_text_writer. An LCD controller model answers each request
// (busy rises one cycle after it sees lcd_enable and stays high for `hold`
// cycles). Every command issued is logged at its rising request edge and
// compared with a text-cursor reference model that turns each pushed
// character into the commands a character LCD needs.
// ---------------------------------------------------------------------------
module tb_lcd_text_writer;

   localparam int DEPTH = 8;
   localparam int COLS  = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic [7:0] wr_char;
   logic       wr_ready;
   logic       lcd_busy;
   logic       lcd_enable;
   logic [9:0] lcd_bus;
   logic [4:0] cursor_col;
   logic       cursor_line;
   logic       idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lcd_text_writer #(.DEPTH(DEPTH), .COLS(COLS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_valid    (wr_valid),
      .wr_char     (wr_char),
      .wr_ready    (wr_ready),
      .lcd_busy    (lcd_busy),
      .lcd_enable  (lcd_enable),
      .lcd_bus     (lcd_bus),
      .cursor_col  (cursor_col),
      .cursor_line (cursor_line),
      .idle        (idle)
   );

   // ---------------- LCD controller model ----------------
   bit ctrl_auto = 1'b0;
   int hold      = 2;
   int busy_cnt  = 0;
   bit arm       = 1'b0;

   always @(negedge clk) begin
      if (ctrl_auto) begin
         if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) lcd_busy = 1'b0;
         end else if (arm) begin
            arm      = 1'b0;
            lcd_busy = 1'b1;
            busy_cnt = hold;
         end else if (lcd_enable) begin
            arm = 1'b1;
         end
      end
   end

   // ---------------- command logger ----------------
   logic       prev_en  = 1'b0;
   logic [9:0] rise_bus = '0;
   int         episodes = 0;
   int         unstable = 0;
   logic [9:0] obs[$];

   always @(negedge clk) begin
      if (lcd_enable === 1'b1 && !prev_en) begin
         obs.push_back(lcd_bus);
         rise_bus = lcd_bus;
         episodes++;
      end else if (lcd_enable === 1'b1 && lcd_bus !== rise_bus) begin
         unstable++;
      end
      prev_en = (lcd_enable === 1'b1);
   end

   // ---------------- reference model ----------------
   int         m_col  = 0;
   int         m_line = 0;
   logic [9:0] exp_q[$];

   task automatic model_char(input logic [7:0] c);
      if (c == 8'h0A) begin
         exp_q.push_back(m_line != 0 ? 10'h080 : 10'h0C0);
         m_line = 1 - m_line;
         m_col  = 0;
      end else if (c == 8'h0C) begin
         exp_q.push_back(10'h001);
         m_line = 0;
         m_col  = 0;
      end else if (m_col < COLS) begin
         exp_q.push_back({2'b10, c});
         m_col++;
      end else begin
`ifdef LCD_WRITER_AUTOWRAP_EN
         exp_q.push_back(m_line != 0 ? 10'h080 : 10'h0C0);
         m_line = 1 - m_line;
         exp_q.push_back({2'b10, c});
         m_col = 1;
`endif
      end
   endtask

   // ---------------- stimulus utilities ----------------
   task automatic ctrl_clear();
      ctrl_auto = 1'b0;
      lcd_busy  = 1'b0;
      busy_cnt  = 0;
      arm       = 1'b0;
   endtask

   task automatic apply_reset();
      ctrl_clear();
      wr_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      m_col  = 0;
      m_line = 0;
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] c);
      int n = 0;
      wr_valid = 1'b1;
      wr_char  = c;
      while (!wr_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout got wr_ready=%0b required 1", wr_ready);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      model_char(c);
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (idle !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (idle !== 1'b1) begin
         errors++;
         $display("FAIL idle_timeout got idle=%0b required 1", idle);
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      ctrl_clear();
      wr_valid = 1'b0;
      wr_char  = 8'h00;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (wr_ready !== 1'b0)    begin errors++; $display("FAIL rst_wr_ready got %0b required 0", wr_ready); end
      checks++; if (idle !== 1'b0)        begin errors++; $display("FAIL rst_idle got %0b required 0", idle); end
      checks++; if (lcd_enable !== 1'b0)  begin errors++; $display("FAIL rst_enable got %0b required 0", lcd_enable); end
      checks++; if (lcd_bus !== 10'h000)  begin errors++; $display("FAIL rst_bus got %03h required 000", lcd_bus); end
      checks++; if (cursor_col !== 5'd0)  begin errors++; $display("FAIL rst_col got %0d required 0", cursor_col); end
      checks++; if (cursor_line !== 1'b0) begin errors++; $display("FAIL rst_line got %0b required 0", cursor_line); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (wr_ready !== 1'b1)    begin errors++; $display("FAIL rel_wr_ready got %0b required 1", wr_ready); end
      checks++; if (idle !== 1'b1)        begin errors++; $display("FAIL rel_idle got %0b required 1", idle); end
      m_col  = 0;
      m_line = 0;
   endtask

   task automatic test_single_char();
      int e0 = episodes;
      obs.delete(); exp_q.delete();
      hold = 51;
      ctrl_auto = 1'b1;
      push(8'h48);
      wait_idle(500);
      checks++; if (episodes - e0 != 1) begin errors++; $display("FAIL h_episodes got %0d required 1", episodes - e0); end
      checks++;
      if (obs.size() < 1 || obs[0] !== exp_q[0]) begin
         errors++; $display("FAIL h_bus got %03h required %03h", (obs.size() > 0) ? obs[0] : 10'h3ff, exp_q[0]);
      end
      checks++; if (cursor_col !== 5'(m_col)) begin errors++; $display("FAIL h_col got %0d required %0d", cursor_col, m_col); end
      checks++; if (idle !== 1'b1)            begin errors++; $display("FAIL h_idle got %0b required 1", idle); end
      hold = 2;
   endtask

   task automatic test_newline();
      logic [7:0] seq [3] = '{8'h41, 8'h0A, 8'h42};
      obs.delete(); exp_q.delete();
      foreach (seq[i]) push(seq[i]);
      wait_idle(500);
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL nl_count got %0d required %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL nl_bus[%0d] got %03h required %03h", i, obs[i], exp_q[i]); end
      end
      checks++; if (cursor_line !== 1'(m_line)) begin errors++; $display("FAIL nl_line got %0b required %0d", cursor_line, m_line); end
      checks++; if (cursor_col !== 5'(m_col))   begin errors++; $display("FAIL nl_col got %0d required %0d", cursor_col, m_col); end
   endtask

   task automatic test_formfeed();
      for (int i = 0; i < 4; i++) push(8'h61);
      wait_idle(500);
      checks++; if (cursor_col !== 5'd5 || cursor_line !== 1'b1) begin
         errors++; $display("FAIL ff_pre got line %0b col %0d required line 1 col 5", cursor_line, cursor_col);
      end
      obs.delete(); exp_q.delete();
      push(8'h0C);
      wait_idle(500);
      checks++; if (obs.size() != 1 || obs[0] !== 10'h001) begin
         errors++; $display("FAIL ff_bus got %0d cmds first %03h required 1 cmd 001", obs.size(), (obs.size() > 0) ? obs[0] : 10'h3ff);
      end
      checks++; if (cursor_line !== 1'b0 || cursor_col !== 5'd0) begin
         errors++; $display("FAIL ff_cursor got line %0b col %0d required line 0 col 0", cursor_line, cursor_col);
      end
   endtask

   task automatic test_wrap();
      push(8'h0C);
      wait_idle(500);
      obs.delete(); exp_q.delete();
      for (int i = 0; i < COLS + 1; i++) push(8'($urandom_range(8'h20, 8'h7E)));
      wait_idle(2000);
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count got %0d required %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_bus[%0d] got %03h required %03h", i, obs[i], exp_q[i]); end
      end
      checks++; if (cursor_line !== 1'(m_line)) begin errors++; $display("FAIL wrap_line got %0b required %0d", cursor_line, m_line); end
      checks++; if (cursor_col !== 5'(m_col))   begin errors++; $display("FAIL wrap_col got %0d required %0d", cursor_col, m_col); end
   endtask

   task automatic test_back_to_back_full();
      int e0;
      int n = 0;
      apply_reset();
      obs.delete(); exp_q.delete();
      e0 = episodes;
      lcd_busy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready[%0d] got %0b required 1", i, wr_ready); end
         wr_valid = 1'b1;
         wr_char  = 8'(8'h30 + i);
         model_char(wr_char);
         @(negedge clk);
      end
      wr_char = 8'h39;
      for (int i = 0; i < 5; i++) begin
         checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_held[%0d] got wr_ready=%0b required 0", i, wr_ready); end
         @(negedge clk);
      end
      checks++; if (episodes != e0) begin errors++; $display("FAIL full_no_enable got %0d episodes required 0", episodes - e0); end
      lcd_busy  = 1'b0;
      busy_cnt  = 0;
      arm       = 1'b0;
      hold      = 2;
      ctrl_auto = 1'b1;
      while (!wr_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++; if (!wr_ready) begin errors++; $display("FAIL full_drain got wr_ready=%0b required 1", wr_ready); end
      @(negedge clk);
      wr_valid = 1'b0;
      model_char(8'h39);
      wait_idle(2000);
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL full_count got %0d required %0d", obs.size(), exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
         checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL full_bus[%0d] got %03h required %03h", i, obs[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      int e0;
      ctrl_clear();
      obs.delete(); exp_q.delete();
      push(8'h5A);
      while (lcd_enable !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (lcd_enable !== 1'b1) begin errors++; $display("FAIL mid_req got enable=%0b required 1", lcd_enable); end
      lcd_busy = 1'b1;
      rst_n    = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (lcd_enable !== 1'b0) begin errors++; $display("FAIL mid_enable got %0b required 0", lcd_enable); end
      checks++; if (lcd_bus !== 10'h000) begin errors++; $display("FAIL mid_bus got %03h required 000", lcd_bus); end
      @(negedge clk);
      checks++; if (idle !== 1'b1)       begin errors++; $display("FAIL mid_empty got idle=%0b required 1", idle); end
      m_col = 0; m_line = 0;
      obs.delete(); exp_q.delete();
      e0 = episodes;
      push(8'h51);
      repeat (10) @(negedge clk);
      checks++; if (episodes != e0) begin errors++; $display("FAIL mid_quiet got %0d requests required 0", episodes - e0); end
      lcd_busy  = 1'b0;
      ctrl_auto = 1'b1;
      wait_idle(500);
      checks++; if (obs.size() != 1 || obs[0] !== exp_q[0]) begin
         errors++; $display("FAIL mid_after got %0d cmds first %03h required 1 cmd %03h", obs.size(), (obs.size() > 0) ? obs[0] : 10'h3ff, exp_q[0]);
      end
      checks++; if (cursor_col !== 5'(m_col)) begin errors++; $display("FAIL mid_col got %0d required %0d", cursor_col, m_col); end
   endtask

   task automatic test_random();
      logic [7:0] c;
      apply_reset();
      ctrl_auto = 1'b1;
      for (int round = 0; round < 2; round++) begin
         obs.delete(); exp_q.delete();
         for (int i = 0; i < 48; i++) begin
            int r = $urandom_range(0, 19);
            hold = $urandom_range(1, 4);
            if (r == 0)      c = 8'h0A;
            else if (r == 1) c = 8'h0C;
            else             c = 8'($urandom_range(8'h20, 8'h7E));
            push(c);
         end
         wait_idle(5000);
         checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d required %0d", obs.size(), exp_q.size()); end
         for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_bus[%0d] got %03h required %03h", i, obs[i], exp_q[i]); end
         end
         checks++; if (cursor_line !== 1'(m_line)) begin errors++; $display("FAIL rnd_line got %0b required %0d", cursor_line, m_line); end
         checks++; if (cursor_col !== 5'(m_col))   begin errors++; $display("FAIL rnd_col got %0d required %0d", cursor_col, m_col); end
      end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bus_stable got %0d changes required 0", unstable); end
   endtask

   initial begin
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_char  = 8'h00;
      lcd_busy = 1'b0;
      test_reset();
      test_single_char();
      test_newline();
      test_formfeed();
      test_wrap();
      test_back_to_back_full();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got time %0t required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
